muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV32M multiply/divide ops in the execute stage.
- Accepts one op at a time via a ready/valid handshake.
- Multiply: drives an external pipelined signed multiplier with sign/zero-extended 33-bit operands and waits a fixed latency.
- Divide/remainder: runs an internal radix-2 restoring divider, one quotient bit per cycle, with RISC-V corner-case handling.
- Holds the pipeline via busy_o until the result is delivered.

---
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: drives an external pipelined multiplier for
// mul ops and runs a radix-2 restoring divider for div/rem ops.
module muldiv_seq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [2:0]              op_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic                    flush_i,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   res_o,
  output logic [DATA_WIDTH:0]     mul_a_o,
  output logic [DATA_WIDTH:0]     mul_b_o,
  input  logic [2*DATA_WIDTH+1:0] mul_res_i
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_RUN,
    S_DIV_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [W-1:0]    pend_q, pend_d;
  logic [W-1:0]    res_q, res_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [W:0]      mul_a_q, mul_a_d;
  logic [W:0]      mul_b_q, mul_b_d;

  logic            sgn_div;
  logic [W-1:0]    a_abs, b_abs;
  logic [W:0]      rem_shift, rem_sub;
  logic            rem_ge;
  logic [W-1:0]    q_fix, r_fix;
  logic            unused_mul_hi;

  assign unused_mul_hi = ^mul_res_i[2*W+1:2*W];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    pend_d  = pend_q;
    res_d   = res_q;
    valid_d = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;

    sgn_div   = op_i[2] & ~op_i[0];
    a_abs     = (sgn_div && a_i[W-1]) ? ('0 - a_i) : a_i;
    b_abs     = (sgn_div && b_i[W-1]) ? ('0 - b_i) : b_i;
    // 33-bit partial remainder so large unsigned divisors cannot overflow
    rem_shift = {rem_q, dvd_q[cnt_q]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    rem_ge    = (rem_shift >= {1'b0, dvs_q});
    q_fix     = q_neg_q ? ('0 - quo_q) : quo_q;
    r_fix     = r_neg_q ? ('0 - rem_q) : rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d = op_i;
          if (!op_i[2]) begin
            mul_a_d = {(op_i != 3'b011) & a_i[W-1], a_i};
            mul_b_d = {(op_i[1] == 1'b0) & b_i[W-1], b_i};
            cnt_d   = CW'(MUL_LATENCY);
            state_d = S_MUL_WAIT;
          end else if (b_i == '0) begin
            pend_d  = op_i[1] ? a_i : '1;
            state_d = S_DONE;
          end else if (sgn_div && a_i == INT_MIN && b_i == '1) begin
            pend_d  = op_i[1] ? '0 : INT_MIN;
            state_d = S_DONE;
          end else begin
            dvd_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(W - 1);
            q_neg_d = sgn_div & (a_i[W-1] ^ b_i[W-1]);
            r_neg_d = sgn_div & a_i[W-1];
            state_d = S_DIV_RUN;
          end
        end
      end
      S_MUL_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DIV_RUN: begin
        rem_d        = rem_ge ? rem_sub[W-1:0] : rem_shift[W-1:0];
        quo_d[cnt_q] = rem_ge;
        if (cnt_q == '0) begin
          state_d = S_DIV_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV_FIX: begin
        pend_d  = op_q[1] ? r_fix : q_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        // res/valid register on the DONE edge, one cycle after the multiplier
        // output has settled for the operands held through MUL_WAIT
        if (op_q[2])              res_d = pend_q;
        else if (op_q == 3'b000)  res_d = mul_res_i[W-1:0];
        else                      res_d = mul_res_i[2*W-1:W];
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      res_d   = res_q;
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      pend_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign res_o   = res_q;
  assign mul_a_o = mul_a_q;
  assign mul_b_o = mul_b_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected result and
// completion cycle; a monitor pops on every valid_o pulse.
module tb_muldiv_seq;

  localparam int unsigned MUL_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] res_o;
  logic [32:0] mul_a_o;
  logic [32:0] mul_b_o;
  logic [65:0] mul_res_i;

  muldiv_seq #(.DATA_WIDTH(32), .MUL_LATENCY(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .flush_i   (flush_i),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .res_o     (res_o),
    .mul_a_o   (mul_a_o),
    .mul_b_o   (mul_b_o),
    .mul_res_i (mul_res_i)
  );

  always #5 clk = ~clk;

  // External pipelined signed multiplier
  logic [65:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= {{33{mul_a_o[32]}}, mul_a_o} * {{33{mul_b_o[32]}}, mul_b_o};
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_res_i = mpipe[MUL_LAT-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    int unsigned id;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks    = 0;
  int unsigned errors    = 0;
  int unsigned n_push    = 0;
  int unsigned valid_cnt = 0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 res_o=%h at cycle %0d, required no pulse", res_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("res_op%0d", e.id), 66'(res_o), 66'(e.res));
        chk($sformatf("latency_op%0d", e.id), 66'(cyc), 66'(e.cyc));
      end
    end
  end

  task automatic do_op(input int unsigned id, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int unsigned lat,
                       input bit expect_done, input bit flush_too);
    int unsigned n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout_op%0d: got ready_o=0, required 1", id);
    end
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    flush_i = flush_too;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    op_i    = 3'($urandom);
    if (expect_done) begin
      e.res = exp_res;
      e.cyc = cyc + lat;
      e.id  = id;
      exp_q.push_back(e);
      n_push++;
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 66'(ready_o), 66'd1);
    chk("reset_busy",  66'(busy_o),  66'd0);
    chk("reset_valid", 66'(valid_o), 66'd0);
    chk("reset_res",   66'(res_o),   66'd0);
    chk("reset_mul_a", 66'(mul_a_o), 66'd0);
    chk("reset_mul_b", 66'(mul_b_o), 66'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply family
    do_op(1, 3'b000, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, MUL_LAT + 1, 1'b1, 1'b0);
    chk("mul_a_signed", 66'(mul_a_o), 66'h1_FFFF_FFFF);
    chk("mul_b_signed", 66'(mul_b_o), 66'h0_0000_0005);
    chk("busy_in_mul",  66'(busy_o),  66'd1);
    do_op(2, 3'b011, 32'hFFFF_FFFF, 32'd5, 32'h0000_0004, MUL_LAT + 1, 1'b1, 1'b0);
    chk("mulhu_a_zext", 66'(mul_a_o), 66'h0_FFFF_FFFF);
    do_op(3, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT + 1, 1'b1, 1'b0);
    chk("mulhsu_a_sext", 66'(mul_a_o), 66'h1_FFFF_FFFF);
    chk("mulhsu_b_zext", 66'(mul_b_o), 66'h0_FFFF_FFFF);
    // flush_i high in IDLE must not block the accept
    do_op(4, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT + 1, 1'b1, 1'b1);
    do_op(5, 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT + 1, 1'b1, 1'b0);

    // Divide family
    do_op(6, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1, 1'b0);
    do_op(7, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1, 1'b0);
    do_op(8, 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b1, 1'b0);
    // start_i held while busy must be ignored
    start_i = 1'b1;
    op_i    = 3'b000;
    a_i     = 32'd3;
    b_i     = 32'd3;
    repeat (20) @(negedge clk);
    chk("busy_in_div", 66'(busy_o), 66'd1);
    start_i = 1'b0;
    do_op(9,  3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b1, 1'b0);
    do_op(10, 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 1'b1, 1'b0);

    // Corner cases
    do_op(11, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1, 1'b0);
    do_op(12, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b1, 1'b0);
    do_op(13, 3'b100, 32'd55, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    do_op(14, 3'b101, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    do_op(15, 3'b111, 32'd123, 32'd0, 32'd123, 1, 1'b1, 1'b0);
    drain();

    // Flush mid-divide
    do_op(16, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'h0, 34, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_ready",    66'(ready_o), 66'd1);
    chk("flush_busy",     66'(busy_o),  66'd0);
    chk("flush_res_hold", 66'(res_o),   66'd123);
    do_op(17, 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT + 1, 1'b1, 1'b0);
    drain();

    // Asynchronous reset between edges during DIV_RUN
    do_op(18, 3'b101, 32'd100, 32'd7, 32'h0, 34, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", 66'(ready_o), 66'd1);
    chk("arst_busy",  66'(busy_o),  66'd0);
    chk("arst_valid", 66'(valid_o), 66'd0);
    chk("arst_res",   66'(res_o),   66'd0);
    chk("arst_mul_a", 66'(mul_a_o), 66'd0);
    chk("arst_mul_b", 66'(mul_b_o), 66'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(19, 3'b101, 32'd1000, 32'd10, 32'd100, 34, 1'b1, 1'b0);
    do_op(20, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b1, 1'b0);
    drain();
    repeat (40) @(negedge clk);

    chk("valid_pulse_count", 66'(valid_cnt), 66'(n_push));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
